// File: rtl/uart_arb_pkg.sv
// Shared types and elaboration-time helpers for the UART transmit arbiter.
// Frame timing: B = CLK_FREQ/UART_BPS clocks per bit, one frame is 10 bits
// (start + 8 data + stop) plus GUARD_CYC idle clocks for transmitter latency.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2
  } arb_state_e;

  // Clocks the arbiter must stay busy per byte handed to uart_tx.
  function automatic int frame_cyc(input int clk_freq, input int bps, input int guard);
    return 10 * (clk_freq / bps) + guard;
  endfunction

  // Width of an unsigned counter able to hold 0..frame.
  function automatic int cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

  // Width of a requester index, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr_i, scanning upward and wrapping at N-1.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down to the pointer so the nearest hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and infers a latch.
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Accepts one byte per grant, pulses tx_flag once, holds tx_data for the
// whole frame and times the frame itself because uart_tx has no busy flag.
// Optional build macro UART_ARB_FRAME_CNT_EN adds a 16-bit sent-frame counter.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int UART_BPS  = 9600,
  parameter  int CLK_FREQ  = 50_000_000,
  parameter  int GUARD_CYC = 4,
  localparam int IW        = idx_width(NUM_REQ)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_flag,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
`ifdef UART_ARB_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int             FRAME_CYC = frame_cyc(CLK_FREQ, UART_BPS, GUARD_CYC);
  localparam int             CW        = cnt_width(FRAME_CYC);
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(FRAME_CYC - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_flag_q, tx_flag_d;
  logic [7:0]    tx_data_q, tx_data_d;
`ifdef UART_ARB_FRAME_CNT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

  logic [IW-1:0] arb_grant;
  logic          arb_any;
  logic          sel_valid;
  logic [7:0]    sel_byte;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // Pick out the granted requester's valid bit and byte.
  always_comb begin
    sel_valid = 1'b0;
    sel_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_byte  = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and accept-pulse logic; state holds unless a case updates it.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tx_flag_d = 1'b0;
    tx_data_d = tx_data_q;
    req_ready = '0;
`ifdef UART_ARB_FRAME_CNT_EN
    frame_cnt_d = frame_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (sel_valid) begin
          req_ready = NUM_REQ'(1) << grant_q;
          tx_data_d = sel_byte;
          tx_flag_d = 1'b1;
          cnt_d     = CNT_LOAD;
          ptr_d     = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d   = SEND;
`ifdef UART_ARB_FRAME_CNT_EN
          frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end else begin
          // Requester withdrew: nothing sent, pointer left where it was.
          state_d = IDLE;
        end
      end
      SEND: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset to the idle/reset values.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (sys_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tx_flag_q <= 1'b0;
      tx_data_q <= 8'h00;
`ifdef UART_ARB_FRAME_CNT_EN
      frame_cnt_q <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tx_flag_q <= tx_flag_d;
      tx_data_q <= tx_data_d;
`ifdef UART_ARB_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign tx_flag  = tx_flag_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
`ifdef UART_ARB_FRAME_CNT_EN
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with B=10, FRAME_CYC=104.
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
// With UART_ARB_FRAME_CNT_EN defined the frame counter is also compared.
module tb_uart_tx_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_flag;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
`ifdef UART_ARB_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_flag = 0;
  int frames = 0;

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .UART_BPS  (100_000),
    .CLK_FREQ  (1_000_000),
    .GUARD_CYC (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_flag   (tx_flag),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
`ifdef UART_ARB_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  // From IDLE with inputs already applied: GRANT cycle, then first SEND cycle.
  task automatic start_frame(input int exp_id, input logic [7:0] exp_byte, input bit chk_gap);
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_id;
    step();
    check("grant_busy", busy, 1);
    check("grant_ready", req_ready, onehot);
    check("grant_id", grant_id, exp_id);
    check("grant_no_flag", tx_flag, 0);
    step();
    check("tx_flag_rise", tx_flag, 1);
    check("tx_data", tx_data, exp_byte);
    check("send_ready_low", req_ready, 0);
    if (chk_gap) check("flag_gap", cyc - last_flag, 106);
    last_flag = cyc;
    frames++;
  endtask

  // Remaining 103 SEND cycles, optional mid-frame valid change, then IDLE.
  task automatic finish_frame(input int exp_id, input logic [7:0] exp_byte, input logic [3:0] mid_valid);
    int bad = 0;
    for (int k = 1; k <= 103; k++) begin
      step();
      if (k == 50) req_valid = mid_valid;
      if (tx_flag !== 1'b0 || tx_data !== exp_byte || busy !== 1'b1 ||
          req_ready !== 4'b0000 || grant_id !== 2'(exp_id)) bad++;
    end
    check("send_hold", bad, 0);
    step();
    check("busy_fall", busy, 0);
    check("busy_fall_time", cyc - last_flag, 104);
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 32'h1312_1110, 0, 8'h10};
    vecs[1]  = '{4'b1111, 32'h1312_1110, 1, 8'h11};
    vecs[2]  = '{4'b1111, 32'h1312_1110, 2, 8'h12};
    vecs[3]  = '{4'b1111, 32'h1312_1110, 3, 8'h13};
    vecs[4]  = '{4'b1111, 32'h1312_1110, 0, 8'h10};
    vecs[5]  = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
    vecs[6]  = '{4'b1011, 32'h3C00_5A69, 3, 8'h3C};
    vecs[7]  = '{4'b0010, 32'h0000_7E00, 1, 8'h7E};
    vecs[8]  = '{4'b0001, 32'h0000_00FF, 0, 8'hFF};
    vecs[9]  = '{4'b1101, 32'h80C3_0001, 2, 8'hC3};
    vecs[10] = '{4'b1001, 32'hE700_0018, 3, 8'hE7};

    sys_rst   = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_flag", tx_flag, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    sys_rst = 1'b0;
    step();

    // Rotation table: all-valid order from reset, then sparse patterns with wrap.
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      start_frame(vecs[i].exp_id, vecs[i].exp_byte, i > 0);
      finish_frame(vecs[i].exp_id, vecs[i].exp_byte, vecs[i].valid);
    end

    // Requester 2 appears while 1 is sending; 0 and 3 also waiting.
    req_valid = 4'b1010;
    req_data  = 32'h4433_2211;
    start_frame(1, 8'h22, 1'b1);
    finish_frame(1, 8'h22, 4'b1101);
    start_frame(2, 8'h33, 1'b1);
    finish_frame(2, 8'h33, 4'b1101);
    start_frame(3, 8'h44, 1'b1);
    finish_frame(3, 8'h44, 4'b1101);
    start_frame(0, 8'h11, 1'b1);
    finish_frame(0, 8'h11, 4'b1101);

    // Requester 1 withdraws during its GRANT cycle; pointer must stay at 1.
    req_valid = 4'b0010;
    req_data  = 32'h0000_5500;
    step();
    check("drop_grant_id", grant_id, 1);
    check("drop_busy", busy, 1);
    req_valid = 4'b0000;
    #1;
    check("drop_no_ready", req_ready, 0);
    step();
    check("drop_idle", busy, 0);
    check("drop_no_flag", tx_flag, 0);
    step();
    check("drop_still_no_flag", tx_flag, 0);
    req_valid = 4'b1010;
    req_data  = 32'h6600_5500;
    start_frame(1, 8'h55, 1'b0);

    // Reset pulse at counter==50 mid-frame (pointer would otherwise be 2).
    for (int k = 0; k < 53; k++) step();
    check("pre_rst_busy", busy, 1);
    sys_rst   = 1'b1;
    req_valid = 4'b0000;
    step();
    frames = 0;
    check("abort_busy", busy, 0);
    check("abort_flag", tx_flag, 0);
    check("abort_data", tx_data, 8'h00);
    check("abort_grant", grant_id, 0);
    check("abort_ready", req_ready, 0);
    sys_rst = 1'b0;
    step();
    check("post_rst_idle", busy, 0);

    // Fresh traffic after reset: pointer restarts at 0.
    req_valid = 4'b1001;
    req_data  = 32'h7700_0088;
    start_frame(0, 8'h88, 1'b0);
    finish_frame(0, 8'h88, 4'b1001);
    start_frame(3, 8'h77, 1'b1);
    finish_frame(3, 8'h77, 4'b1001);
    start_frame(0, 8'h88, 1'b1);
    finish_frame(0, 8'h88, 4'b1001);

`ifdef UART_ARB_FRAME_CNT_EN
    check("frame_cnt", frame_cnt, frames);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
